// File: rtl/ball_engine.sv
// Ball physics for the pong datapath: sub-pixel position/velocity, serve/play/score
// sequencing, wall reflection, paddle deflection with speed-up and zone steering.
module ball_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int BORDER       = 8,
  parameter int BALL_SIDE    = 8,
  parameter int FRAC_W       = 4,
  parameter int V_W          = 8,
  parameter int BASE_VX      = 32,
  parameter int SPEEDUP      = 4,
  parameter int MAX_VX       = 96,
  parameter int ZONE_VY      = 24,
  parameter int SERVE_FRAMES = 60
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           enable_i,
  input  logic           frame_i,
  input  logic [3:0]     rnd_i,
  input  logic           hit_left_i,
  input  logic           hit_right_i,
  input  logic [1:0]     zone_left_i,
  input  logic [1:0]     zone_right_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic [V_W-1:0] vx_o,
  output logic [V_W-1:0] vy_o,
  output logic [1:0]     state_o,
  output logic           miss_left_o,
  output logic           miss_right_o
);

  localparam int PX_W  = X_W + FRAC_W;
  localparam int PY_W  = Y_W + FRAC_W;
  localparam int SX_W  = PX_W + 1;
  localparam int SY_W  = PY_W + 1;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SERVE_WAIT = 2'd1;
  localparam logic [1:0] PLAY       = 2'd2;
  localparam logic [1:0] SCORED     = 2'd3;

  localparam logic [PX_W-1:0]        X_CENTRE  = PX_W'(((H_RES - BALL_SIDE) / 2) << FRAC_W);
  localparam logic [PY_W-1:0]        Y_CENTRE  = PY_W'(((V_RES - BALL_SIDE) / 2) << FRAC_W);
  localparam logic signed [SX_W-1:0] X_LO      = SX_W'(BORDER << FRAC_W);
  localparam logic signed [SX_W-1:0] X_HI      = SX_W'((H_RES - BORDER - BALL_SIDE) << FRAC_W);
  localparam logic signed [SY_W-1:0] Y_LO      = SY_W'(BORDER << FRAC_W);
  localparam logic signed [SY_W-1:0] Y_HI      = SY_W'((V_RES - BORDER - BALL_SIDE) << FRAC_W);
  localparam logic signed [V_W-1:0]  BASE_V    = V_W'(BASE_VX);
  localparam logic signed [V_W-1:0]  ZONE_V    = V_W'(ZONE_VY);
  localparam logic signed [V_W:0]    SPEEDUP_V = (V_W + 1)'(SPEEDUP);
  localparam logic signed [V_W:0]    MAX_V     = (V_W + 1)'(MAX_VX);
  localparam logic [CNT_W-1:0]       SERVE_CNT = CNT_W'(SERVE_FRAMES);

  logic [1:0]              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    dir_q;
  logic [PX_W-1:0]         px_q;
  logic [PY_W-1:0]         py_q;
  logic signed [V_W-1:0]   vx_q, vy_q;
  logic                    miss_l_q, miss_r_q;

  logic                    hit_l, hit_r, miss_l, miss_r;
  logic [1:0]              zone;
  logic signed [V_W:0]     vx_ext, vx_mag, vx_fast;
  logic signed [V_W-1:0]   vx_nxt, vy_nxt, vy_wall, vy_serve;
  logic [V_W-1:0]          vy_serve_mag;
  logic signed [SX_W-1:0]  x_nxt;
  logic signed [SY_W-1:0]  y_nxt;
  logic [PY_W-1:0]         y_wall;

  // One frame of play: paddle deflection first, then motion with the new
  // velocity, computed with a guard bit so an edge crossing cannot wrap.
  always_comb begin
    hit_l   = hit_left_i && (vx_q < 0);
    hit_r   = hit_right_i && (vx_q > 0);
    zone    = hit_l ? zone_left_i : zone_right_i;
    vx_ext  = {vx_q[V_W-1], vx_q};
    vx_mag  = vx_ext[V_W] ? -vx_ext : vx_ext;
    vx_fast = vx_mag + SPEEDUP_V;
    if (vx_fast > MAX_V) vx_fast = MAX_V;

    vx_nxt = vx_q;
    vy_nxt = vy_q;
    if (hit_l || hit_r) begin
      vx_nxt = hit_l ? $signed(vx_fast[V_W-1:0]) : -$signed(vx_fast[V_W-1:0]);
      if (zone == 2'b01)      vy_nxt = -ZONE_V;
      else if (zone == 2'b10) vy_nxt = ZONE_V;
    end

    x_nxt  = {1'b0, px_q} + {{(SX_W - V_W){vx_nxt[V_W-1]}}, vx_nxt};
    y_nxt  = {1'b0, py_q} + {{(SY_W - V_W){vy_nxt[V_W-1]}}, vy_nxt};
    miss_l = x_nxt < X_LO;
    miss_r = x_nxt > X_HI;

    y_wall  = y_nxt[PY_W-1:0];
    vy_wall = vy_nxt;
    if (y_nxt < Y_LO) begin
      y_wall  = Y_LO[PY_W-1:0];
      vy_wall = -vy_nxt;
    end else if (y_nxt > Y_HI) begin
      y_wall  = Y_HI[PY_W-1:0];
      vy_wall = -vy_nxt;
    end

    vy_serve_mag = V_W'({rnd_i[2:1], 3'b000});
    vy_serve     = rnd_i[3] ? -$signed(vy_serve_mag) : $signed(vy_serve_mag);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      px_q     <= X_CENTRE;
      py_q     <= Y_CENTRE;
      vx_q     <= '0;
      vy_q     <= '0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
      if (!enable_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        px_q    <= X_CENTRE;
        py_q    <= Y_CENTRE;
        vx_q    <= '0;
        vy_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= SERVE_WAIT;
            cnt_q   <= SERVE_CNT;
            dir_q   <= rnd_i[0];
          end
          SERVE_WAIT: begin
            if (frame_i) begin
              if (cnt_q == CNT_W'(1)) begin
                state_q <= PLAY;
                vx_q    <= dir_q ? -BASE_V : BASE_V;
                vy_q    <= vy_serve;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          PLAY: begin
            if (frame_i) begin
              // A miss wins over the wall step; the next serve heads at the loser.
              if (miss_l || miss_r) begin
                state_q  <= SCORED;
                px_q     <= X_CENTRE;
                py_q     <= Y_CENTRE;
                vx_q     <= '0;
                vy_q     <= '0;
                miss_l_q <= miss_l;
                miss_r_q <= miss_r;
                dir_q    <= miss_l;
              end else begin
                px_q <= x_nxt[PX_W-1:0];
                py_q <= y_wall;
                vx_q <= vx_nxt;
                vy_q <= vy_wall;
              end
            end
          end
          default: begin
            state_q <= SERVE_WAIT;
            cnt_q   <= SERVE_CNT;
          end
        endcase
      end
    end
  end

  assign x_o          = px_q[PX_W-1:FRAC_W];
  assign y_o          = py_q[PY_W-1:FRAC_W];
  assign vx_o         = vx_q;
  assign vy_o         = vy_q;
  assign state_o      = state_q;
  assign miss_left_o  = miss_l_q;
  assign miss_right_o = miss_r_q;

endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball-physics engine for the pong datapath. It owns ball position and velocity in sub-pixel fixed point and runs a serve/play/score state machine. It handles wall reflection, paddle deflection with speed-up and hit-zone steering, and emits one-cycle miss events to the score logic. It sits between the per-frame strobe, the paddle collision detectors and the sprite/score outputs.

## Interface

- H_RES, 640, screen width in pixels
- V_RES, 480, screen height in pixels
- X_W, 10, integer x width
- Y_W, 10, integer y width
- BORDER, 8, playfield margin in pixels
- BALL_SIDE, 8, ball side in pixels
- FRAC_W, 4, position/velocity fraction bits (1 LSB = 1/16 px)
- V_W, 8, signed two's-complement velocity width, units of 1 LSB
- BASE_VX, 32, serve |vx| (2 px/frame)
- SPEEDUP, 4, |vx| added per paddle hit
- MAX_VX, 96, |vx| saturation value
- ZONE_VY, 24, |vy| imposed by an edge-zone hit
- SERVE_FRAMES, 60, frames waited before a serve; must be ≥1

Ports:

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous assert, active-low
- enable_i  in  1  game running; low forces IDLE
- frame_i  in  1  one-cycle strobe per video frame
- rnd_i  in  4  random bits, sampled at serve
- hit_left_i  in  1  ball overlaps left paddle
- hit_right_i  in  1  ball overlaps right paddle
- zone_left_i  in  2  left hit zone: 01 top, 10 bottom, 00/11 middle
- zone_right_i  in  2  right hit zone, same encoding
- x_o  out  X_W  ball x, integer pixels
- y_o  out  Y_W  ball y, integer pixels
- vx_o  out  V_W  current vx
- vy_o  out  V_W  current vy
- state_o  out  2  IDLE=0, SERVE_WAIT=1, PLAY=2, SCORED=3
- miss_left_o  out  1  one-cycle pulse: ball left via left edge
- miss_right_o  out  1  one-cycle pulse: ball left via right edge

## Operation

- Centre position: XC = (H_RES−BALL_SIDE)/2 = 316, YC = (V_RES−BALL_SIDE)/2 = 236, fraction 0.
- Limits: YTOP = BORDER = 8, YBOT = V_RES−BORDER−BALL_SIDE = 464, XL = BORDER = 8, XR = H_RES−BORDER−BALL_SIDE = 624.
- Position registers hold X_W+FRAC_W bits. Arithmetic is signed with one guard bit, so left/top underflow is detected rather than wrapped.
- IDLE: ball at centre, vx=vy=0. enable_i=1 → SERVE_WAIT, serve counter = SERVE_FRAMES, serve direction taken from rnd_i[0] (1 = left/negative).
- SERVE_WAIT: each frame_i decrements the counter. A frame_i with counter==1 → PLAY and loads velocity:
  - vx = ±BASE_VX per the stored direction.
  - vy = rnd_i[2:1]·8, negated if rnd_i[3]=1.
- PLAY, on a frame_i cycle, in this order:
  - Paddle: hit_left_i is honoured only if vx<0; hit_right_i only if vx>0. At most one can apply.
  - A hit sets |vx| = min(|vx|+SPEEDUP, MAX_VX) and reverses the sign of vx.
  - Zone 01 → vy = −ZONE_VY; zone 10 → vy = +ZONE_VY; otherwise vy unchanged.
  - Motion: x += vx, y += vy (the new velocity is used).
  - Miss: x_new < XL → miss_left; x_new > XR → miss_right. A miss has precedence over the wall step.
  - Wall: y_new < YTOP → y = YTOP, vy = −vy; y_new > YBOT → y = YBOT, vy = −vy.
- Miss → SCORED: ball at centre, vx=vy=0, miss pulse asserted. Stored serve direction points toward the side that missed.
- SCORED → SERVE_WAIT unconditionally on the next cycle, counter = SERVE_FRAMES.
- enable_i=0 in any state → IDLE next cycle. This centres the ball, zeroes velocity and counter, and suppresses any miss. It overrides frame_i and hits.
- Hit inputs are ignored outside PLAY and on cycles without frame_i.

## Timing

- Every output is registered. Reset values: x_o=316, y_o=236, vx_o=0, vy_o=0, state_o=0, miss pulses 0.
- Reset asserts asynchronously and deasserts synchronously to clk_i.
- Motion latency: outputs reflect a frame_i update on the following cycle.
- Miss pulse is high for exactly one cycle, coincident with state_o=3. state_o=1 follows on the next cycle.
- Serve: PLAY is entered on the cycle after the SERVE_FRAMES-th frame_i counted in SERVE_WAIT.
- x_o and y_o are the integer parts of the position, with the fraction truncated.

## Test plan

- Reset mid-PLAY → outputs immediately 316/236/0/0/IDLE, no miss pulse.
- enable_i=1, rnd_i=4'b0011 → after 60 frame_i pulses: state 2, vx=−32, vy=+8. Next frame: x_o=314, y_o=236 (fraction 0.5).
- Top wall, vy=−24 → y_o clamps to 8, vy=+24 on the crossing frame, and x continues unaffected.
- Left paddle, vx=−32:
  - hit_left_i=1, zone 01 on a frame → vx=+36, vy=−24.
  - Repeated alternating hits saturate |vx| at 96.
  - hit_left_i with vx>0 → no change.
- No hit → x crosses below 8 → miss_left_o pulses once, state 3 for one cycle, ball centred. Next serve has vx=−32 regardless of rnd_i[0].
- enable_i dropped during PLAY, same cycle as frame_i and hit_right_i → next cycle IDLE, centred, vx=vy=0, no miss pulse.
